stream_mux_rr: RTL and testbench

Parametrised N-channel valid/ready stream multiplexer with a registered output stage, replacing the combinational 2:1 mux wherever data crosses between streaming blocks. Selection is software-steered (fixed channel) or round-robin fair, selected at run time. Optional packet locking keeps a grant until the granted channel's last beat has transferred. Output carries data, last flag and the index of the source channel.

---
 rtl/stream_mux_pkg.sv | 41 ++++
 rtl/stream_mux_reg.sv | 43 ++++
 rtl/stream_mux_rr.sv | 132 +++++++++++++
 tb/tb_stream_mux_rr.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_pkg
// Purpose  : Shared constants and the round-robin pick helper for the
//            stream_mux_rr channel multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Upper bound on channel count the pick helper can scan.
    localparam int MAX_N     = 32;
    localparam int MAX_IDX_W = 5;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan n channels starting after ptr, wrapping; return first valid one.
    function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]     valid,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input int                   n);
        rr_pick_t r;
        int       c;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            c = (int'(ptr) + k) % n;
            if ((k <= n) && !r.found && valid[c[MAX_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = c[MAX_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_reg.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_reg
// Purpose  : Single-entry valid/ready output register. Loads when the
//            producer asserts load (only while accept is high), drains on
//            downstream ready.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_accept
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    // Hold one beat; a load in the same cycle as a drain replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_accept = !r_valid || i_ready;

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Purpose  : N-channel valid/ready stream mux with registered output,
//            fixed or round-robin selection, forwarding data/last/channel.
//            Optional packet locking enabled by STREAM_MUX_PKT_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sel_mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [SW-1:0]  out_chan
);

    logic [SW-1:0]     r_ptr;
    rr_pick_t          w_rr;
    logic              w_fix_ok;
    logic              w_grant_ok;
    logic [SW-1:0]     w_grant;
    logic              w_accept;
    logic              w_xfer;
    logic [W-1:0]      w_sel_data;
    logic              w_sel_last;
    logic [W+SW:0]     w_reg_data;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic              r_lock;
    logic [SW-1:0]     r_lock_chan;
`endif

    assign w_rr = rr_pick(MAX_N'(in_valid), MAX_IDX_W'(r_ptr), N);

    // Fixed index is out of range only when N is not a power of two.
    if ((2 ** SW) == N) begin : g_fix_full
        assign w_fix_ok = 1'b1;
    end else begin : g_fix_part
        assign w_fix_ok = (int'(sel) < N);
    end

    // Grant selection: lock overrides both fixed and round-robin modes.
    always_comb begin
        w_grant_ok = 1'b0;
        w_grant    = '0;
        if (sel_mode == MODE_RR) begin
            w_grant_ok = w_rr.found;
            w_grant    = SW'(w_rr.idx);
        end else begin
            w_grant_ok = w_fix_ok;
            w_grant    = sel;
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (r_lock) begin
            w_grant_ok = 1'b1;
            w_grant    = r_lock_chan;
        end
`endif
    end

    // Ready is one-hot on the granted channel and forced low in reset.
    for (genvar i = 0; i < N; i++) begin : g_ready
        assign in_ready[i] = rst_n && w_accept && w_grant_ok && (w_grant == SW'(i));
    end

    assign w_xfer = |(in_valid & in_ready);

    // Route the granted channel's data and last flag to the register.
    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SW'(i)) begin
                w_sel_data = in_data[i*W +: W];
                w_sel_last = in_last[i];
            end
        end
    end

    stream_mux_reg #(
        .DW (W + 1 + SW)
    ) u_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_xfer),
        .i_data   ({w_sel_last, w_grant, w_sel_data}),
        .i_ready  (out_ready),
        .o_valid  (out_valid),
        .o_data   (w_reg_data),
        .o_accept (w_accept)
    );

    assign {out_last, out_chan, out_data} = w_reg_data;

    // Round-robin pointer follows the last granted channel in either mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SW'(N - 1);
        end else if (w_xfer) begin
            r_ptr <= w_grant;
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Lock onto a channel mid-packet; release after its last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock      <= 1'b0;
            r_lock_chan <= '0;
        end else if (w_xfer) begin
            r_lock      <= !w_sel_last;
            r_lock_chan <= w_grant;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_rr
// Purpose  : Self-checking bench for stream_mux_rr (N=4 main instance plus
//            an N=5 instance for out-of-range fixed select). Lock behaviour
//            is checked when STREAM_MUX_PKT_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    typedef struct packed {
        logic [1:0] chan;
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel_mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_chan;

    logic        sel_mode5;
    logic [2:0]  sel5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic        out_valid5;
    logic [7:0]  out_data5;
    logic        out_last5;
    logic [2:0]  out_chan5;

    logic [7:0]  dat [4];
    beat_t       q [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.N(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sel_mode(sel_mode), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_chan(out_chan)
    );

    stream_mux_rr #(.N(5), .W(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .sel_mode(sel_mode5), .sel(sel5),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(40'h0),
        .in_last(5'h0), .out_valid(out_valid5), .out_ready(1'b1),
        .out_data(out_data5), .out_last(out_last5), .out_chan(out_chan5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic last);
        beat_t b;
        b.chan = ch;
        b.last = last;
        b.data = dat[ch];
        q.push_back(b);
    endtask

    // Scoreboard: every beat leaving the output is matched against the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_beat", {22'h0, out_chan, out_last, out_data}, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = q.pop_front();
                check("beat", {22'h0, out_chan, out_last, out_data}, {22'h0, e.chan, e.last, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'hA5; dat[3] = 8'h43;
        in_data   = {dat[3], dat[2], dat[1], dat[0]};
        in_last   = 4'hF;
        sel       = 2'd0;
        sel_mode5 = 1'b0;
        sel5      = 3'd0;
        in_valid5 = 5'h1F;

        // Reset with every channel requesting
        rst_n     = 1'b0;
        sel_mode  = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready",  {28'h0, in_ready}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data",  {24'h0, out_data}, 32'h0);
        check("rst_out_chan",  {30'h0, out_chan}, 32'h0);
        check("rst_out_last",  {31'h0, out_last}, 32'h0);

        // Round-robin, all valid: 0,1,2,3 twice, then drop ch1: 0,2,3,0
        rst_n = 1'b1;
        #1;
        check("rr_first_ready", {28'h0, in_ready}, 32'h1);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) push(2'(c), 1'b1);
        repeat (8) tick();
        in_valid = 4'b1101;
        push(2'd0, 1'b1); push(2'd2, 1'b1); push(2'd3, 1'b1); push(2'd0, 1'b1);
        repeat (4) tick();
        in_valid = 4'h0;
        tick();
        check("rr_drained", {31'h0, out_valid}, 32'h0);

        // Fixed select ch2
        sel_mode = 1'b0;
        sel      = 2'd2;
        in_valid = 4'hF;
        #1;
        check("fix_ready", {28'h0, in_ready}, 32'h4);
        push(2'd2, 1'b1);
        tick();
        in_valid = 4'h0;
        #1;
        check("fix_out_valid", {31'h0, out_valid}, 32'h1);
        check("fix_out_data",  {24'h0, out_data}, 32'hA5);
        check("fix_out_chan",  {30'h0, out_chan}, 32'h2);
        check("fix_ready_novalid", {28'h0, in_ready}, 32'h4);
        tick();

        // Out-of-range fixed select on the N=5 instance
        sel5 = 3'd5;
        #1;
        check("sel_ge_n_ready", {27'h0, in_ready5}, 32'h0);
        sel5 = 3'd4;
        #1;
        check("sel_max_ready", {27'h0, in_ready5}, 32'h10);

        // Backpressure: hold ch1 beat for 5 cycles
        out_ready = 1'b0;
        sel       = 2'd1;
        in_valid  = 4'hF;
        push(2'd1, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_in_ready",  {28'h0, in_ready}, 32'h0);
            check("bp_out_chan",  {30'h0, out_chan}, 32'h1);
            check("bp_out_data",  {24'h0, out_data}, 32'h21);
            tick();
        end
        sel       = 2'd3;
        out_ready = 1'b1;
        push(2'd3, 1'b1);
        #1;
        check("bp_release_ready", {28'h0, in_ready}, 32'h8);
        tick();
        in_valid = 4'h0;
        #1;
        check("bp_replace_valid", {31'h0, out_valid}, 32'h1);
        check("bp_replace_chan",  {30'h0, out_chan}, 32'h3);
        tick();

        // Packet: ch1 sends 3 beats while ch0/ch2 also request
        sel_mode = 1'b1;
        in_valid = 4'b0001;
        push(2'd0, 1'b1);
        tick();
        in_valid = 4'b0111;
        in_last  = 4'b1101;
`ifdef STREAM_MUX_PKT_LOCK_EN
        push(2'd1, 1'b0); push(2'd1, 1'b0); push(2'd1, 1'b1);
        push(2'd2, 1'b1); push(2'd0, 1'b1);
`else
        push(2'd1, 1'b0); push(2'd2, 1'b1); push(2'd0, 1'b1);
        push(2'd1, 1'b1); push(2'd2, 1'b1);
`endif
        tick();
        tick();
        in_last = 4'hF;
        repeat (3) tick();
        in_valid = 4'h0;
        tick();

        // Reset mid-packet with a held beat
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        in_last   = 4'b1101;
        tick();
        check("mid_held_valid", {31'h0, out_valid}, 32'h1);
        check("mid_held_chan",  {30'h0, out_chan}, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_chan",  {30'h0, out_chan}, 32'h0);
        check("mid_rst_ready", {28'h0, in_ready}, 32'h0);
        tick();
        rst_n    = 1'b1;
        in_valid = 4'b0111;
        in_last  = 4'hF;
        #1;
        check("post_rst_ready", {28'h0, in_ready}, 32'h1);
        out_ready = 1'b1;
        push(2'd0, 1'b1);
        tick();
        in_valid = 4'h0;
        repeat (3) tick();
        check("queue_empty", q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
